if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction fetch stage; sits directly upstream of the control decoder.
- Owns the PC, issues word fetches to instruction memory over a valid/ready request port, and buffers returned instructions in a small FIFO.
- Presents {pc, instr, opcode} to decode with a valid/ready handshake. out_opcode is instr[6:0] and drives the control decoder opcode input.
- Accepts branch redirects from execute, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_req_addr  out  32  fetch byte address, word aligned.
- imem_resp_valid  in  1  response data valid, one per accepted request, in order.
- imem_resp_data  in  32  fetched instruction word.
- redirect_valid  in  1  branch taken / PC redirect.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes instruction.
- out_pc  out  32  PC of the presented instruction.
- out_instr  out  32  presented instruction.
- out_opcode  out  7  out_instr[6:0].

Behaviour:
Reset (async assert):
- pc=RESET_PC; FIFO empty; state=REQ; outstanding=0; discard=0.
- imem_req_valid=0 while rst is high. out_valid=0, out_pc=0, out_instr=0.
- First request is asserted in the first cycle after rst deasserts, with addr=RESET_PC.

FSM, two states:
- REQ: imem_req_valid=1 iff (fifo_count + outstanding) < DEPTH; addr=pc.
  - On accept (valid & ready): outstanding=1, pc<=pc+4, go to WAIT.
- WAIT: imem_req_valid=0.
  - On imem_resp_valid: outstanding=0, go to REQ.
  - The response is pushed into the FIFO with the pc of that request, unless discard=1; if dropped, discard is cleared.
- At most one request is outstanding.
- Throughput with a zero-wait memory: one instruction per 2 cycles.

Request stability:
- While imem_req_valid=1 and not accepted, addr holds, except on redirect.

Redirect (highest priority, any state):
- pc<=redirect_pc with bits [1:0] forced to 00.
- FIFO flushed: out_valid=0 next cycle.
- If a request is outstanding, or is accepted in the redirect cycle: discard<=1 and its response is dropped. The FSM still waits for that response before issuing the new address.
- If in REQ with no outstanding request: the next cycle requests redirect_pc.
- A response arriving in the redirect cycle is dropped.
- A pop in the redirect cycle is allowed; the consumer still sees the presented instruction that cycle.

FIFO:
- Registered; a response in cycle N gives out_valid in cycle N+1.
- Pop on out_valid & out_ready.
- Push and pop in the same cycle are legal.
- The credit rule guarantees a push never hits a full FIFO. Overflow is impossible and must be flagged by assertion.
- out_* outputs hold their value while out_valid & !out_ready.

Arithmetic:
- pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

Reset mid-operation:
- Outstanding, discard and FIFO are cleared immediately.
- A late imem response after reset with outstanding=0 is ignored.

Test Plan:
- Reset release, zero-wait memory returning addr^32'h13, out_ready=1 -> requests 0x0,0x4,0x8 every 2nd cycle; out_pc 0x0/0x4/0x8 with matching instr; out_opcode=instr[6:0].
- out_ready=0 for 10 cycles -> exactly 2 instructions buffered (0x0, 0x4); imem_req_valid=0 while full; outputs stable; releasing ready pops in order with no loss or duplication.
- imem_req_ready low 3 cycles -> imem_req_addr held at 0x8 throughout; accepted on 4th cycle; next addr 0xC.
- redirect_valid with redirect_pc=0x103 while request 0x8 is outstanding -> FIFO flushed; 0x8 response dropped; next request addr 0x100; first out_pc after redirect is 0x100.
- redirect in the same cycle as imem_resp_valid, and redirect in REQ while imem_req_ready=0 -> response dropped; request switches to the target address; no stale instruction reaches decode.
- PC wrap: RESET_PC=32'hFFFF_FFF8 -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000. Separately, rst asserted mid-WAIT -> outputs zero immediately; a late response is ignored; restart fetch from RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches
// and buffers returned instructions in a small FIFO in front of the decoder.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [6:0]  out_opcode
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [31:0]      req_pc;
  logic             discard, discard_nxt;
  logic             req_valid_c;
  logic             req_fire;
  logic             push;
  logic             pop;

  logic [31:0]      fifo_pc    [DEPTH];
  logic [31:0]      fifo_instr [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  // Low address bits of a redirect target are dropped to keep fetches word aligned.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Only one request may be in flight, so in REQ the credit is simply FIFO space.
  assign req_valid_c    = (state == S_REQ) && (count < CNT_W'(DEPTH));
  assign req_fire       = req_valid_c && imem_req_ready;
  assign imem_req_valid = req_valid_c && !rst;
  assign imem_req_addr  = pc;

  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_pc     = fifo_pc[rd_ptr];
  assign out_instr  = fifo_instr[rd_ptr];
  assign out_opcode = out_instr[6:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      req_pc  <= '0;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      discard <= discard_nxt;
      if (req_fire) req_pc <= pc;
    end
  end

  // Next state, PC and response filtering; a redirect overrides the PC in any state
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    push        = 1'b0;
    case (state)
      S_REQ: begin
        if (req_fire) begin
          state_nxt = S_WAIT;
          pc_nxt    = pc + 32'd4;
          if (redirect_valid) discard_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
          push        = !discard && !redirect_valid;
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (redirect_valid) pc_nxt = {redirect_pc[31:2], 2'b00};
  end

  // Instruction FIFO; a redirect empties it on the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= req_pc;
        fifo_instr[wr_ptr] <= imem_resp_data;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // The credit rule must make a push into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule
